// File: rtl/fp_arith_pkg.sv
// Shared opcodes, status bit positions and channel FSM encoding for fp_arith_bank.
package fp_arith_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ACC = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam int unsigned ST_BUSY = 0;
  localparam int unsigned ST_DONE = 1;
  localparam int unsigned ST_OVF  = 2;
  localparam int unsigned ST_ERR  = 3;
  localparam int unsigned ST_W    = 4;

  localparam int unsigned PWM_W    = 8;
  localparam logic [7:0]  PWM_FULL = 8'hFF;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } chan_state_e;

endpackage

// File: rtl/fp_arith_chan.sv
// One arithmetic channel: add/sub/accumulate in one cycle, shift-add multiply when
// FP_ARITH_MUL_EN is defined, otherwise opcode 11 is rejected with err.
module fp_arith_chan
  import fp_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             okClk,
  input  logic             reset,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [1:0]       op_sel,
  input  logic             start,
  input  logic             clear,
  output logic [WIDTH-1:0] result,
  output logic [ST_W-1:0]  status
);

  chan_state_e      state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;

  logic [WIDTH:0] add_full;
  logic [WIDTH:0] sub_full;
  logic [WIDTH:0] acc_full;

  assign add_full = {1'b0, a_q} + {1'b0, b_q};
  assign sub_full = {1'b0, a_q} - {1'b0, b_q};
  assign acc_full = {1'b0, result} + {1'b0, a_q};

`ifdef FP_ARITH_MUL_EN
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  // one multiplier bit consumed per CALC cycle
  assign prod_nxt = mplier[0] ? (prod + mcand) : prod;
`endif

  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      result <= '0;
      status <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= OP_ADD;
`ifdef FP_ARITH_MUL_EN
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      cnt    <= '0;
`endif
    end else if (clear) begin
      state  <= S_IDLE;
      result <= '0;
      status <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state           <= S_CALC;
            a_q             <= op_a;
            b_q             <= op_b;
            op_q            <= op_sel;
            status[ST_BUSY] <= 1'b1;
            status[ST_DONE] <= 1'b0;
            status[ST_ERR]  <= 1'b0;
            // accumulate overflow is sticky across accumulate runs only
            if (op_sel != OP_ACC) status[ST_OVF] <= 1'b0;
`ifdef FP_ARITH_MUL_EN
            mcand  <= {{WIDTH{1'b0}}, op_a};
            mplier <= op_b;
            prod   <= '0;
            cnt    <= '0;
`endif
          end
        end
        S_CALC: begin
          case (op_q)
            OP_ADD: begin
              result          <= add_full[WIDTH-1:0];
              status[ST_OVF]  <= add_full[WIDTH];
              state           <= S_DONE;
              status[ST_BUSY] <= 1'b0;
              status[ST_DONE] <= 1'b1;
            end
            OP_SUB: begin
              result          <= sub_full[WIDTH-1:0];
              status[ST_OVF]  <= sub_full[WIDTH];
              state           <= S_DONE;
              status[ST_BUSY] <= 1'b0;
              status[ST_DONE] <= 1'b1;
            end
            OP_ACC: begin
              result          <= acc_full[WIDTH-1:0];
              status[ST_OVF]  <= status[ST_OVF] | acc_full[WIDTH];
              state           <= S_DONE;
              status[ST_BUSY] <= 1'b0;
              status[ST_DONE] <= 1'b1;
            end
            OP_MUL: begin
`ifdef FP_ARITH_MUL_EN
              prod   <= prod_nxt;
              mcand  <= mcand << 1;
              mplier <= mplier >> 1;
              cnt    <= cnt + CNT_W'(1);
              if (cnt == CNT_W'(WIDTH - 1)) begin
                result          <= prod_nxt[WIDTH-1:0];
                status[ST_OVF]  <= |prod_nxt[2*WIDTH-1:WIDTH];
                state           <= S_DONE;
                status[ST_BUSY] <= 1'b0;
                status[ST_DONE] <= 1'b1;
              end
`else
              status[ST_ERR]  <= 1'b1;
              status[ST_OVF]  <= 1'b0;
              state           <= S_DONE;
              status[ST_BUSY] <= 1'b0;
              status[ST_DONE] <= 1'b1;
`endif
            end
            default: state <= S_IDLE;
          endcase
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/fp_arith_bank.sv
// Bank of NCH independent arithmetic channels plus an active-low LED PWM driver.
// Multiply support is enabled by defining FP_ARITH_MUL_EN.
module fp_arith_bank
  import fp_arith_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned NCH   = 2,
  parameter int unsigned LED_W = 8
) (
  input  logic               okClk,
  input  logic               reset,
  input  logic [NCH*WIDTH-1:0] op_a,
  input  logic [NCH*WIDTH-1:0] op_b,
  input  logic [NCH*2-1:0]   op_sel,
  input  logic [NCH-1:0]     start,
  input  logic [NCH-1:0]     clear,
  output logic [NCH*WIDTH-1:0] result,
  output logic [NCH*ST_W-1:0] status,
  input  logic [LED_W-1:0]   led_pat,
  input  logic [7:0]         led_duty,
  output logic [LED_W-1:0]   led
);

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    fp_arith_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .okClk  (okClk),
      .reset  (reset),
      .op_a   (op_a[g*WIDTH +: WIDTH]),
      .op_b   (op_b[g*WIDTH +: WIDTH]),
      .op_sel (op_sel[g*2 +: 2]),
      .start  (start[g]),
      .clear  (clear[g]),
      .result (result[g*WIDTH +: WIDTH]),
      .status (status[g*ST_W +: ST_W])
    );
  end

  logic [PWM_W-1:0] pwm_cnt;

  // full duty bypasses the compare so lit LEDs never blink off at cnt=255
  always_ff @(posedge okClk or posedge reset) begin
    if (reset) begin
      pwm_cnt <= '0;
      led     <= '1;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_W'(1);
      if (led_duty == PWM_FULL) led <= ~led_pat;
      else                      led <= ~(led_pat & {LED_W{pwm_cnt < led_duty}});
    end
  end

endmodule

// File: tb/tb_fp_arith_bank.sv
// Directed self-checking bench for fp_arith_bank; expectations follow FP_ARITH_MUL_EN.
module tb_fp_arith_bank;
  import fp_arith_pkg::*;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned NCH   = 2;
  localparam int unsigned LED_W = 8;
`ifdef FP_ARITH_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic                 okClk = 1'b0;
  logic                 reset;
  logic [NCH*WIDTH-1:0] op_a, op_b;
  logic [NCH*2-1:0]     op_sel;
  logic [NCH-1:0]       start, clear;
  logic [NCH*WIDTH-1:0] result;
  logic [NCH*4-1:0]     status;
  logic [LED_W-1:0]     led_pat;
  logic [7:0]           led_duty;
  logic [LED_W-1:0]     led;

  fp_arith_bank #(.WIDTH(WIDTH), .NCH(NCH), .LED_W(LED_W)) dut (
    .okClk(okClk), .reset(reset), .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
    .start(start), .clear(clear), .result(result), .status(status),
    .led_pat(led_pat), .led_duty(led_duty), .led(led)
  );

  always #5 okClk = ~okClk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [WIDTH-1:0] last_res [NCH];

  typedef struct {
    int         ch;
    logic [1:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic       ovf;
    logic       pre_clear;
    int         lat;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge okClk);
    #1;
  endtask

  function automatic logic [3:0] st(input int ch);
    return status[ch*4 +: 4];
  endfunction

  function automatic logic [WIDTH-1:0] res(input int ch);
    return result[ch*WIDTH +: WIDTH];
  endfunction

  task automatic pulse_clear(input int ch);
    clear[ch] = 1'b1;
    step();
    clear[ch] = 1'b0;
    last_res[ch] = '0;
  endtask

  task automatic load(input int ch, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    op_a[ch*WIDTH +: WIDTH] = a;
    op_b[ch*WIDTH +: WIDTH] = b;
    op_sel[ch*2 +: 2]       = op;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    logic [31:0] e_res;
    logic        e_ovf, e_err;
    int          e_lat, n;
    string       tag;
    tag = $sformatf("vec%0d", idx);
    e_res = v.res; e_ovf = v.ovf; e_err = 1'b0; e_lat = v.lat;
    if (v.pre_clear) begin
      pulse_clear(v.ch);
      check({tag, "_clr_status"}, 64'(st(v.ch)), 64'h0);
      check({tag, "_clr_result"}, 64'(res(v.ch)), 64'h0);
    end
    if (v.op == OP_MUL && !MUL_EN) begin
      e_res = last_res[v.ch]; e_ovf = 1'b0; e_err = 1'b1; e_lat = 1;
    end
    load(v.ch, v.op, v.a, v.b);
    start[v.ch] = 1'b1;
    step();
    start[v.ch] = 1'b0;
    check({tag, "_busy"}, 64'(st(v.ch)[ST_BUSY]), 64'h1);
    check({tag, "_hold"}, 64'(res(v.ch)), 64'(last_res[v.ch]));
    n = 0;
    while (st(v.ch)[ST_BUSY] && n < 40) begin
      step();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(e_lat));
    check({tag, "_result"}, 64'(res(v.ch)), 64'(e_res));
    check({tag, "_status"}, 64'(st(v.ch)), 64'({e_err, e_ovf, 1'b1, 1'b0}));
    last_res[v.ch] = e_res;
    step();
    check({tag, "_done_held"}, 64'(st(v.ch)[ST_DONE]), 64'h1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int low_cnt [LED_W];
    int bad;
    logic [LED_W-1:0] pat;

    vecs[0]  = '{0, OP_ADD, 32'hFFFF_FFFF, 32'd2,        32'h1,          1'b1, 1'b1, 1};
    vecs[1]  = '{0, OP_ADD, 32'd1,         32'd2,        32'd3,          1'b0, 1'b0, 1};
    vecs[2]  = '{1, OP_SUB, 32'd5,         32'd7,        32'hFFFF_FFFE,  1'b1, 1'b1, 1};
    vecs[3]  = '{1, OP_SUB, 32'd10,        32'd3,        32'd7,          1'b0, 1'b0, 1};
    vecs[4]  = '{1, OP_SUB, 32'd5,         32'd5,        32'd0,          1'b0, 1'b0, 1};
    vecs[5]  = '{0, OP_ACC, 32'h8000_0000, 32'd0,        32'h8000_0000,  1'b0, 1'b1, 1};
    vecs[6]  = '{0, OP_ACC, 32'h8000_0000, 32'd0,        32'h0,          1'b1, 1'b0, 1};
    vecs[7]  = '{0, OP_ACC, 32'h8000_0000, 32'd0,        32'h8000_0000,  1'b1, 1'b0, 1};
    vecs[8]  = '{0, OP_ADD, 32'd0,         32'd0,        32'd0,          1'b0, 1'b0, 1};
    vecs[9]  = '{1, OP_MUL, 32'd1234,      32'd5678,     32'd7006652,    1'b0, 1'b0, 32};
    vecs[10] = '{0, OP_MUL, 32'h0001_0000, 32'h0001_0000, 32'h0,         1'b1, 1'b0, 32};
    vecs[11] = '{1, OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1,         1'b1, 1'b0, 32};

    reset = 1'b1; op_a = '0; op_b = '0; op_sel = '0; start = '0; clear = '0;
    led_pat = '0; led_duty = '0;
    for (int c = 0; c < NCH; c++) last_res[c] = '0;
    #12;
    check("reset_result", 64'(result), 64'h0);
    check("reset_status", 64'(status), 64'h0);
    check("reset_led", 64'(led), 64'hFF);
    @(negedge okClk);
    reset = 1'b0;
    step();
    check("post_reset_status", 64'(status), 64'h0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // clear together with start while a multiply is in flight
    load(0, OP_ADD, 32'd9, 32'd9);
    start[0] = 1'b1; step(); start[0] = 1'b0; step(); step();
    check("pre_clr_result", 64'(res(0)), 64'd18);
    load(0, OP_MUL, 32'd3, 32'd3);
    start[0] = 1'b1; step(); start[0] = 1'b0; step(); step();
    start[0] = 1'b1; clear[0] = 1'b1;
    step();
    start[0] = 1'b0; clear[0] = 1'b0;
    check("clr_start_status", 64'(st(0)), 64'h0);
    check("clr_start_result", 64'(res(0)), 64'h0);
    step();
    check("clr_start_idle", 64'(st(0)), 64'h0);
    last_res[0] = '0;

    // second start on a busy channel is ignored; other channel runs normally
    load(1, OP_ADD, 32'd1, 32'd1);
    start[1] = 1'b1; step(); start[1] = 1'b0;
    load(1, OP_ADD, 32'd100, 32'd100);
    load(0, OP_ADD, 32'd3, 32'd4);
    start = 2'b11; step(); start = 2'b00;
    check("busy_ch1_result", 64'(res(1)), 64'd2);
    check("busy_ch0_busy", 64'(st(0)), 64'h1);
    step();
    check("busy_ch0_result", 64'(res(0)), 64'd7);
    check("busy_ch0_status", 64'(st(0)), 64'h2);
    step(); step();
    check("busy_ch1_kept", 64'(res(1)), 64'd2);

    // simultaneous starts on both channels
    load(0, OP_SUB, 32'd50, 32'd8);
    load(1, OP_ADD, 32'd40, 32'd2);
    start = 2'b11; step(); start = 2'b00; step();
    check("simul_ch0", 64'(res(0)), 64'd42);
    check("simul_ch1", 64'(res(1)), 64'd42);
    check("simul_status", 64'(status), 64'h22);

    // reset in the middle of a multiply
    load(1, OP_MUL, 32'd3, 32'd3);
    start[1] = 1'b1; step(); start[1] = 1'b0; step(); step();
    reset = 1'b1;
    #2;
    check("rst_mid_result", 64'(result), 64'h0);
    check("rst_mid_status", 64'(status), 64'h0);
    check("rst_mid_led", 64'(led), 64'hFF);
    @(negedge okClk);
    reset = 1'b0;
    for (int k = 0; k < 40; k++) step();
    check("rst_abort_result", 64'(result), 64'h0);
    check("rst_abort_status", 64'(status), 64'h0);

    // LED PWM
    pat = 8'hA5;
    led_pat = pat; led_duty = 8'd64;
    step(); step();
    for (int b = 0; b < LED_W; b++) low_cnt[b] = 0;
    for (int k = 0; k < 256; k++) begin
      for (int b = 0; b < LED_W; b++) if (!led[b]) low_cnt[b]++;
      step();
    end
    for (int b = 0; b < LED_W; b++)
      check($sformatf("pwm64_bit%0d", b), 64'(low_cnt[b]), pat[b] ? 64'd64 : 64'd0);

    led_duty = 8'd255;
    step(); step();
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      if (led !== 8'h5A) bad++;
      step();
    end
    check("pwm255_const", 64'(bad), 64'd0);

    led_duty = 8'd0;
    step(); step();
    check("pwm0_off", 64'(led), 64'hFF);

    reset = 1'b1;
    #2;
    check("led_reset", 64'(led), 64'hFF);
    @(negedge okClk);
    reset = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
